// File: rtl/probe_detector_mc.sv
// Multi-channel probe detector: fires trigger pulses, waits a settle time, then
// counts high probe samples per channel over AVER_TIME periods.
module probe_detector_mc #(
  parameter int NUM_CH       = 4,
  parameter int CNT_WIDTH    = 14,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 4,
  parameter int SETTLE_CYC   = 2,
  parameter int AVER_DEFAULT = 10000,
  parameter int SW_WIDTH     = 4
) (
  input  logic                  shifting_clk,
  input  logic                  shifting_rst,
  input  logic                  native_en,
  input  logic                  native_wr,
  input  logic [ADDR_WIDTH-1:0] native_addr,
  input  logic [DATA_WIDTH-1:0] native_data_in,
  output logic [DATA_WIDTH-1:0] native_data_out,
  output logic                  native_ready,
  input  logic [NUM_CH-1:0]     probe_in,
  output logic                  trigger_out,
  output logic [SW_WIDTH-1:0]   sw,
  output logic                  done_irq
);

  // state  | meaning
  // IDLE   | waiting for start, or for cont to be set
  // LOAD   | first trigger of a run; clear accumulators, load sample count
  // TRIG   | trigger for every later sample of the run
  // SETTLE | wait SETTLE_CYC cycles for the device to respond
  // SAMPLE | add synchronised probe levels into the accumulators
  // LATCH  | copy accumulators to RESULT, raise new_data and done_irq
  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_TRIG, ST_SETTLE, ST_SAMPLE, ST_LATCH
  } state_t;

  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam logic [ADDR_WIDTH-1:0] A_CTRL   = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] A_STATUS = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] A_AVER   = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] A_SW     = ADDR_WIDTH'(3);

  state_t state, state_next;
  logic cont, new_data, busy;
  logic wr_ctrl, start_req, abort_req, rd_status;
  logic [CNT_WIDTH-1:0]  aver_time, remaining;
  logic [SET_W-1:0]      settle_cnt;
  logic [CNT_WIDTH-1:0]  acc    [NUM_CH];
  logic [CNT_WIDTH-1:0]  result [NUM_CH];
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  unused_data;

  (* ASYNC_REG = "TRUE" *) logic [NUM_CH-1:0] sync_q1;
  (* ASYNC_REG = "TRUE" *) logic [NUM_CH-1:0] sync_q2;

  assign busy        = (state != ST_IDLE);
  assign wr_ctrl     = native_en & native_wr & (native_addr == A_CTRL);
  assign start_req   = wr_ctrl & native_data_in[0];
  assign abort_req   = wr_ctrl & native_data_in[2];
  assign rd_status   = native_en & ~native_wr & (native_addr == A_STATUS);
  assign unused_data = ^native_data_in;

  always_ff @(posedge shifting_clk) begin
    if (shifting_rst) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= probe_in;
      sync_q2 <= sync_q1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (start_req || cont) state_next = ST_LOAD;
      ST_LOAD:   state_next = ST_SETTLE;
      ST_TRIG:   state_next = ST_SETTLE;
      ST_SETTLE: if (settle_cnt == SET_W'(1)) state_next = ST_SAMPLE;
      ST_SAMPLE: state_next = (remaining == CNT_WIDTH'(1)) ? ST_LATCH : ST_TRIG;
      ST_LATCH:  state_next = cont ? ST_LOAD : ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
    // abort outranks everything, including a start in the same write
    if (abort_req) state_next = ST_IDLE;
  end

  always_ff @(posedge shifting_clk) begin
    if (shifting_rst) begin
      state       <= ST_IDLE;
      trigger_out <= 1'b0;
      done_irq    <= 1'b0;
      remaining   <= '0;
      settle_cnt  <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        acc[k]    <= '0;
        result[k] <= '0;
      end
    end else begin
      state       <= state_next;
      trigger_out <= (state_next == ST_LOAD) || (state_next == ST_TRIG);
      done_irq    <= (state_next == ST_LATCH);
      case (state)
        ST_LOAD: begin
          for (int k = 0; k < NUM_CH; k++) acc[k] <= '0;
          remaining  <= (aver_time == '0) ? CNT_WIDTH'(1) : aver_time;
          settle_cnt <= SET_W'(SETTLE_CYC);
        end
        ST_TRIG:   settle_cnt <= SET_W'(SETTLE_CYC);
        ST_SETTLE: settle_cnt <= settle_cnt - SET_W'(1);
        ST_SAMPLE: begin
          for (int k = 0; k < NUM_CH; k++) acc[k] <= acc[k] + CNT_WIDTH'(sync_q2[k]);
          remaining <= remaining - CNT_WIDTH'(1);
        end
        ST_LATCH: begin
          if (!abort_req) begin
            for (int k = 0; k < NUM_CH; k++) result[k] <= acc[k];
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    case (native_addr)
      A_CTRL:   rd_data = DATA_WIDTH'({cont, 1'b0});
      A_STATUS: rd_data = DATA_WIDTH'({new_data, busy});
      A_AVER:   rd_data = DATA_WIDTH'(aver_time);
      A_SW:     rd_data = DATA_WIDTH'(sw);
      default: begin
        for (int k = 0; k < NUM_CH; k++) begin
          if (native_addr == ADDR_WIDTH'(4 + k)) rd_data = DATA_WIDTH'(result[k]);
        end
      end
    endcase
  end

  always_ff @(posedge shifting_clk) begin
    if (shifting_rst) begin
      native_ready    <= 1'b0;
      native_data_out <= '0;
      sw              <= '0;
      cont            <= 1'b0;
      new_data        <= 1'b0;
      aver_time       <= CNT_WIDTH'(AVER_DEFAULT);
    end else begin
      native_ready    <= native_en;
      native_data_out <= (native_en && !native_wr) ? rd_data : '0;
      if (native_en && native_wr) begin
        case (native_addr)
          A_CTRL:  cont      <= native_data_in[1];
          A_AVER:  aver_time <= native_data_in[CNT_WIDTH-1:0];
          A_SW:    sw        <= native_data_in[SW_WIDTH-1:0];
          default: ;
        endcase
      end
      // a latch in the same cycle as a STATUS read keeps the flag set
      if (state == ST_LATCH && !abort_req) new_data <= 1'b1;
      else if (rd_status)                   new_data <= 1'b0;
    end
  end

endmodule

// File: tb/tb_probe_detector_mc.sv
// Self-checking bench for probe_detector_mc: directed register/run sequence with
// random probe levels scored by a per-run sample-count model.
module tb_probe_detector_mc;
  localparam int NUM_CH     = 4;
  localparam int CNT_WIDTH  = 14;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 4;
  localparam int SETTLE_CYC = 2;
  localparam int AVER_DEF   = 10000;
  localparam int SW_WIDTH   = 4;
  localparam int PERIOD     = SETTLE_CYC + 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  en = 1'b0;
  logic                  wr = 1'b0;
  logic [ADDR_WIDTH-1:0] addr = '0;
  logic [DATA_WIDTH-1:0] din = '0;
  logic [DATA_WIDTH-1:0] dout;
  logic                  ready;
  logic [NUM_CH-1:0]     probe;
  logic                  trig;
  logic [SW_WIDTH-1:0]   sw;
  logic                  done;

  probe_detector_mc #(
    .NUM_CH(NUM_CH), .CNT_WIDTH(CNT_WIDTH), .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH), .SETTLE_CYC(SETTLE_CYC), .AVER_DEFAULT(AVER_DEF),
    .SW_WIDTH(SW_WIDTH)
  ) dut (
    .shifting_clk(clk), .shifting_rst(rst), .native_en(en), .native_wr(wr),
    .native_addr(addr), .native_data_in(din), .native_data_out(dout),
    .native_ready(ready), .probe_in(probe), .trigger_out(trig), .sw(sw),
    .done_irq(done)
  );

  initial forever #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_done = 0;
  int last_len = 0;
  int epoch = 0;
  int pat_len = 0;
  logic [NUM_CH-1:0] pat [8];
  logic [NUM_CH-1:0] samples [$];
  int exp_res [NUM_CH];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Reference model: every trigger starts one sample period; the level applied
  // during that trigger cycle is what the run must count for that sample.
  initial begin
    logic [NUM_CH-1:0] v;
    int cnt;
    int seen_epoch;
    seen_epoch = 0;
    probe = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        samples.delete();
        for (int k = 0; k < NUM_CH; k++) exp_res[k] = 0;
      end else begin
        if (epoch != seen_epoch) begin
          samples.delete();
          seen_epoch = epoch;
        end
        if (done) begin
          for (int k = 0; k < NUM_CH; k++) begin
            cnt = 0;
            foreach (samples[i]) cnt += int'(samples[i][k]);
            exp_res[k] = cnt;
          end
          last_len = samples.size();
          samples.delete();
          n_done++;
        end else if (trig) begin
          v = (samples.size() < pat_len) ? pat[samples.size()] : NUM_CH'($urandom);
          probe = v;
          samples.push_back(v);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_write(input logic [ADDR_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] d);
    en = 1'b1; wr = 1'b1; addr = a; din = d;
    tick();
    en = 1'b0; wr = 1'b0;
    chk("wr_ready", ready, 1);
  endtask

  task automatic reg_read(input logic [ADDR_WIDTH-1:0] a, output logic [DATA_WIDTH-1:0] d);
    en = 1'b1; wr = 1'b0; addr = a;
    tick();
    en = 1'b0;
    d = dout;
    chk("rd_ready", ready, 1);
  endtask

  task automatic wait_done();
    int c;
    c = 0;
    while (!done && c < 400) begin
      tick();
      c++;
    end
    chk("done_seen", done, 1);
  endtask

  task automatic check_results(input string tag);
    logic [DATA_WIDTH-1:0] d;
    for (int k = 0; k < NUM_CH; k++) begin
      reg_read(ADDR_WIDTH'(4 + k), d);
      chk($sformatf("%s_res%0d", tag, k), d, exp_res[k]);
    end
  endtask

  // single (non-continuous) run; returns one cycle after the done pulse
  task automatic do_run(input int n, input bit start_mid);
    int load_cyc;
    int neff;
    neff = (n == 0) ? 1 : n;
    reg_write(2, n);
    reg_write(0, 1);
    chk("load_trig", trig, 1);
    load_cyc = cyc;
    if (start_mid) begin
      repeat (3) tick();
      reg_write(0, 1);
    end
    wait_done();
    chk("run_latency", cyc - load_cyc, PERIOD * neff);
    tick();
    chk("samples_taken", last_len, neff);
  endtask

  initial begin
    logic [DATA_WIDTH-1:0] d;
    int load_cyc;
    int saved;
    int n;

    repeat (3) tick();
    rst = 1'b0;
    chk("rst_trig", trig, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", ready, 0);
    chk("rst_dout", dout, 0);
    chk("rst_sw", sw, 0);
    reg_read(2, d); chk("rst_aver", d, AVER_DEF);
    reg_read(3, d); chk("rst_swreg", d, 0);
    reg_read(1, d); chk("rst_status", d, 0);
    reg_read(0, d); chk("rst_ctrl", d, 0);
    reg_read(4, d); chk("rst_result0", d, 0);
    reg_read(9, d); chk("unmapped_rd", d, 0);
    tick();
    chk("ready_one_cycle", ready, 0);
    reg_write(9, 32'hFFFF_FFFF);
    reg_read(3, d); chk("unmapped_wr_sw", d, 0);

    // fixed 0101 pattern over 5 samples
    for (int i = 0; i < 5; i++) pat[i] = 4'b0101;
    pat_len = 5;
    do_run(5, 1'b0);
    pat_len = 0;
    check_results("fixed");
    reg_read(1, d); chk("status_after_run", d, 2);
    reg_read(1, d); chk("status_reread", d, 0);

    // channel 1 high only on samples 2 and 4; start mid-run must be ignored
    for (int i = 0; i < 5; i++) begin
      pat[i] = NUM_CH'($urandom);
      pat[i][1] = (i == 1 || i == 3);
    end
    pat_len = 5;
    saved = n_done;
    do_run(5, 1'b1);
    pat_len = 0;
    check_results("ch1");
    reg_read(5, d); chk("ch1_count", d, 2);
    reg_read(1, d); chk("status_ch1", d, 2);
    repeat (10) tick();
    chk("busy_start_ignored", n_done, saved + 1);
    chk("idle_no_trig", trig, 0);

    // AVER_TIME 0 behaves as 1; STATUS read during LATCH sees old new_data
    reg_write(2, 0);
    reg_write(0, 1);
    load_cyc = cyc;
    wait_done();
    chk("aver0_latency", cyc - load_cyc, PERIOD);
    reg_read(1, d); chk("status_in_latch", d, 1);
    reg_read(1, d); chk("status_after_latch", d, 2);
    chk("aver0_samples", last_len, 1);
    check_results("aver0");

    reg_write(2, 32'hFFFF_0007);
    reg_read(2, d); chk("aver_trunc", d, 7);

    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 6);
      do_run(n, 1'b0);
      check_results($sformatf("rand%0d", r));
      reg_read(1, d); chk("rand_status", d, 2);
    end

    reg_write(3, 32'hA);
    chk("sw_a", sw, 4'hA);
    d = $urandom;
    reg_write(3, d);
    chk("sw_rand", sw, d[3:0]);
    reg_read(3, d); chk("sw_readback", d, sw);

    // continuous mode: LATCH directly followed by LOAD
    reg_write(2, 3);
    reg_write(0, 2);
    reg_read(0, d); chk("ctrl_cont", d, 2);
    chk("cont_load_trig", trig, 1);
    load_cyc = cyc;
    wait_done();
    chk("cont_lat1", cyc - load_cyc, 3 * PERIOD);
    tick();
    chk("cont_adjacent1", trig, 1);
    chk("cont_samples1", last_len, 3);
    load_cyc = cyc;
    check_results("cont1");
    wait_done();
    chk("cont_lat2", cyc - load_cyc, 3 * PERIOD);
    tick();
    chk("cont_adjacent2", trig, 1);
    load_cyc = cyc;
    reg_write(0, 0);
    wait_done();
    chk("cont_lat3", cyc - load_cyc, 3 * PERIOD);
    tick();
    chk("cont_stop", trig, 0);
    chk("cont_samples3", last_len, 3);
    check_results("cont3");

    // abort mid-run: IDLE next cycle, RESULT and new_data untouched
    reg_write(0, 2);
    saved = n_done;
    repeat (6) tick();
    reg_write(0, 4);
    chk("abort_trig", trig, 0);
    reg_read(1, d); chk("abort_status", d, 2);
    epoch++;
    check_results("abort");
    repeat (20) tick();
    chk("abort_no_done", n_done, saved);
    chk("abort_idle_trig", trig, 0);

    // start and abort together: abort wins
    reg_write(0, 5);
    chk("startabort_trig", trig, 0);
    reg_read(1, d); chk("startabort_status", d, 0);

    // synchronous reset mid-run
    reg_write(2, 5);
    reg_write(0, 1);
    repeat (6) tick();
    saved = n_done;
    rst = 1'b1;
    tick();
    chk("midrst_trig", trig, 0);
    chk("midrst_done", done, 0);
    rst = 1'b0;
    reg_read(1, d); chk("midrst_status", d, 0);
    reg_read(2, d); chk("midrst_aver", d, AVER_DEF);
    reg_read(3, d); chk("midrst_sw", d, 0);
    epoch++;
    check_results("midrst");
    repeat (30) tick();
    chk("midrst_no_done", n_done, saved);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
